// File: rtl/adder_pipe_stage.sv
// Two-stage valid/ready adder: stage 1 registers operands, a ripple-carry chain
// feeds stage 2 (sum + flags). Optional signed saturation under `ADDER_SAT_EN`.
module adder_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [CNT_W-1:0] res_count,
  output logic [CNT_W-1:0] ovf_count
);
  localparam int MSB = WIDTH - 1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_in1_q, s1_in1_d;
  logic [WIDTH-1:0] s1_in2_q, s1_in2_d;
  logic             s1_cin_q, s1_cin_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic             s1_advance;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             c_out_c;
  logic             ovf_c;
  logic [WIDTH-1:0] sum_sel;

  // in_ready never looks at in_valid, so upstream may wait on it safely.
  assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s1_advance;
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid_q && out_ready;

  always_comb begin : ripple
    carry    = '0;
    sum_c    = '0;
    carry[0] = s1_cin_q;
    for (int i = 0; i < WIDTH; i++) begin
      sum_c[i]     = s1_in1_q[i] ^ s1_in2_q[i] ^ carry[i];
      carry[i+1]   = (s1_in1_q[i] & s1_in2_q[i]) |
                     (carry[i] & (s1_in1_q[i] ^ s1_in2_q[i]));
    end
  end

  assign c_out_c = carry[WIDTH];
  assign ovf_c   = (s1_in1_q[MSB] == s1_in2_q[MSB]) && (sum_c[MSB] != s1_in1_q[MSB]);

`ifdef ADDER_SAT_EN
  // On overflow both operands share a sign, so in1's MSB picks the rail.
  assign sum_sel = !ovf_c ? sum_c :
                   (s1_in1_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign sum_sel = sum_c;
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_in1_d    = s1_in1_q;
    s1_in2_d    = s1_in2_q;
    s1_cin_d    = s1_cin_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    res_count_d = res_count_q;
    ovf_count_d = ovf_count_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_in1_d   = in1;
      s1_in2_d   = in2;
      s1_cin_d   = c_in;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (s1_advance) begin
      out_valid_d = 1'b1;
      sum_d       = sum_sel;
      c_out_d     = c_out_c;
      ovf_d       = ovf_c;
      zero_d      = (sum_sel == '0);
      neg_d       = sum_sel[MSB];
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    if (out_xfer) begin
      res_count_d = res_count_q + 1'b1;
      if (ovf_q) ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_in1_q    <= '0;
      s1_in2_q    <= '0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      res_count_q <= '0;
      ovf_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_in1_q    <= s1_in1_d;
      s1_in2_q    <= s1_in2_d;
      s1_cin_q    <= s1_cin_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      res_count_q <= res_count_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign res_count = res_count_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_adder_pipe_stage.sv
// Scoreboard bench for adder_pipe_stage: driver pushes expected results,
// a negedge monitor pops and compares on each output handshake.
module tb_adder_pipe_stage;
  localparam int W = 32;
  localparam int CW = 16;

`ifdef ADDER_SAT_EN
  localparam logic [W-1:0] OVP_SUM = 32'h7FFF_FFFF;
  localparam logic [W-1:0] OVN_SUM = 32'h8000_0000;
`else
  localparam logic [W-1:0] OVP_SUM = 32'h8000_0000;
  localparam logic [W-1:0] OVN_SUM = 32'h0000_0000;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic          c_in = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          c_out, ovf, zero, neg;
  logic [CW-1:0] res_count, ovf_count;

  int   checks = 0;
  int   errors = 0;
  int   cnt_exp = 0;
  int   ovf_exp = 0;
  int   rdy_mode = 1;  // 0: stall, 1: always ready, 2: random
  exp_t q[$];

  adder_pipe_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf),
    .zero(zero), .neg(neg), .res_count(res_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b0;
    else if (rdy_mode == 1) out_ready = 1'b1;
    else                    out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t r;
    logic [W:0] t;
    t    = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    r.s  = t[W-1:0];
    r.co = t[W];
    r.ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
`ifdef ADDER_SAT_EN
    if (r.ov) r.s = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  logic         held = 1'b0;
  logic [W-1:0] held_sum;
  always @(negedge clk) begin
    if (rst_n) begin
      if (held && out_valid) chk("hold_sum", sum, held_sum);
      held     = out_valid && !out_ready;
      held_sum = sum;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("c_out", 32'(c_out), 32'(e.co));
          chk("ovf", 32'(ovf), 32'(e.ov));
          chk("zero", 32'(zero), 32'(e.s == '0));
          chk("neg", 32'(neg), 32'(e.s[W-1]));
          cnt_exp++;
          if (e.ov) ovf_exp++;
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  // Call at a negedge; returns at a negedge.
  task automatic try_send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input exp_t e, input int bound, output bit ok);
    in1 = a; in2 = b; c_in = c; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (in_ready) begin
        q.push_back(e);
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  vec_t vecs[6] = '{
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OVP_SUM,       1'b0, 1'b1},
    '{32'hFFFF_FFF6, 32'h0000_0005, 1'b0, 32'hFFFF_FFFB, 1'b0, 1'b0},
    '{32'hFFFF_FFF6, 32'hFFFF_FFFB, 1'b0, 32'hFFFF_FFF1, 1'b1, 1'b0},
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, OVN_SUM,       1'b1, 1'b1}
  };

  initial begin
    bit           ok;
    int           acc;
    exp_t         e;
    logic [W-1:0] s_hold;
    logic [W-1:0] ra, rb;
    logic         rc;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", 32'({c_out, ovf, zero, neg}), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: accepted at edge 0, s1 after it, out_valid one edge later.
    e = '{s: vecs[0].s, co: vecs[0].co, ov: vecs[0].ov};
    try_send(vecs[0].a, vecs[0].b, vecs[0].c, e, 10, ok);
    chk("lat_accept", 32'(ok), 32'd1);
    chk("lat_stage1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_stage2", 32'(out_valid), 32'd1);

    for (int i = 1; i < 6; i++) begin
      e = '{s: vecs[i].s, co: vecs[i].co, ov: vecs[i].ov};
      try_send(vecs[i].a, vecs[i].b, vecs[i].c, e, 10, ok);
      if (!ok) chk("dir_accept", 32'(ok), 32'd1);
    end

    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < 2; c++) begin
          e = '{s: 32'(a + b + c), co: 1'b0, ov: 1'b0};
          try_send(32'(a), 32'(b), 1'(c), e, 10, ok);
          if (!ok) chk("sweep_accept", 32'(ok), 32'd1);
        end
    drain(50);
    chk("res_count_206", 32'(res_count), 32'd206);
    chk("ovf_count_2", 32'(ovf_count), 32'd2);
    chk("res_count_sb", 32'(res_count), 32'(cnt_exp));

    // Backpressure: only two triples fit.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      ra = 32'(100 * (k + 1)); rb = 32'(7 + k);
      try_send(ra, rb, 1'b1, model(ra, rb, 1'b1), 3, ok);
      acc += int'(ok);
    end
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    s_hold = sum;
    repeat (3) @(negedge clk);
    chk("bp_sum_stable", sum, s_hold);
    chk("bp_sum_first", sum, 32'd108);
    rdy_mode = 1;
    drain(50);
    chk("bp_res_count", 32'(res_count), 32'(cnt_exp));

    // Reset with two results buffered.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      try_send(32'h55, 32'h11, 1'b0, model(32'h55, 32'h11, 1'b0), 3, ok);
      if (!ok) chk("rst_fill_accept", 32'(ok), 32'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_res_count", 32'(res_count), 32'd0);
    chk("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    cnt_exp = 0;
    ovf_exp = 0;
    rdy_mode = 1;
    repeat (6) @(negedge clk);
    chk("no_stale", 32'(out_valid), 32'd0);

    // Streaming with random backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (n % 7 == 0) rb = ra;
      try_send(ra, rb, rc, model(ra, rb, rc), 50, ok);
      if (!ok) chk("rand_accept", 32'(ok), 32'd1);
    end
    rdy_mode = 1;
    drain(100);
    chk("rand_res_count", 32'(res_count), 32'(cnt_exp % 65536));
    chk("rand_ovf_count", 32'(ovf_count), 32'(ovf_exp % 65536));
    chk("rand_total", 32'(cnt_exp), 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_pipe_stage.md
Name: adder_pipe_stage

Overview:
- Registered, handshaked wrapper stage around the 32-bit ripple-carry adder datapath.
- Accepts operand triples (in1, in2, c_in) from an upstream valid/ready stream and registers them into stage 1.
- Computes the sum with a WIDTH-bit ripple-carry chain of full-adder cells, then registers sum, carry and status flags into stage 2 for the downstream consumer.
- Supports full throughput under backpressure and counts completed results and signed overflows.

Parameters:
- WIDTH, 32, operand/sum width in bits; min 2.
- CNT_W, 16, width of the completed-result and overflow counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: synchronous, active-low, sampled on rising clk.
- in_valid  input  1  upstream operand triple valid.
- in_ready  output  1  stage can accept an operand triple this cycle.
- in1  input  WIDTH  operand A, two's complement.
- in2  input  WIDTH  operand B, two's complement.
- c_in  input  1  carry-in.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  registered sum.
- c_out  output  1  unsigned carry-out.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].
- res_count  output  CNT_W  number of results consumed downstream.
- ovf_count  output  CNT_W  number of consumed results with ovf=1.

Behaviour:
- Reset (rst_n=0 at a clk edge): s1_valid, out_valid, sum, c_out, ovf, zero, neg, res_count, ovf_count all go to 0. Stage-1 operand registers also clear to 0.
- Reset mid-operation: all in-flight data is dropped; no result appears after reset deassertion.
- Input handshake:
  - Transfer occurs when in_valid && in_ready at a clk edge.
  - in_ready = !s1_valid || s1_advance, where s1_advance = s1_valid && (!out_valid || out_ready).
  - in_ready is combinational from out_valid, out_ready and s1_valid only, never from in_valid.
- Stage 1 holds in1, in2, c_in and s1_valid. It loads on an input transfer. If it advances with no new transfer, s1_valid drops to 0.
- Adder: combinational ripple chain over the stage-1 registers.
  - {c_out_c, sum_c} = s1_in1 + s1_in2 + s1_cin, computed at WIDTH+1 bits.
  - ovf_c = (s1_in1[MSB] == s1_in2[MSB]) && (sum_c[MSB] != s1_in1[MSB]).
- Stage 2 loads sum_c, c_out_c, ovf_c, zero, neg when s1_advance. out_valid is set on that edge.
- Output handshake: a transfer occurs when out_valid && out_ready. If no new data loads in the same cycle, out_valid clears.
- While out_valid && !out_ready, all stage-2 outputs stay stable.
- Latency: 2 clk from input transfer to out_valid, with no backpressure. Throughput is 1 result/clk.
- Backpressure buffering: the stage holds up to 2 results (stage 1 + stage 2). With out_ready=0 it accepts exactly 2 triples, then in_ready=0.
- Simultaneous events: input transfer, s1 advance and output transfer in one cycle all occur together. Data order is preserved and no result is lost or duplicated.
- Counters:
  - res_count increments on each output transfer.
  - ovf_count increments on each output transfer with ovf=1.
  - Both wrap modulo 2^CNT_W, with no saturation.
- Flag arithmetic:
  - c_out is the unsigned carry.
  - ovf is the signed overflow.
  - zero and neg describe the registered sum as emitted.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined: when ovf_c=1, stage 2 loads a signed-saturated sum.
  - Both operands positive: sum = 0x7FFF_FFFF (for WIDTH=32).
  - Both operands negative: sum = 0x8000_0000.
  - zero and neg are computed from the saturated value.
  - c_out and ovf are unchanged (ovf still 1).
- Not defined: sum is the wrapped modulo-2^WIDTH result; no saturation logic is present.

Test Plan:
- Basic: after reset, sweep in1=0..9 × in2=0..9 × c_in=0..1 with out_ready=1 -> each sum = in1+in2+c_in arriving 2 clk after acceptance, c_out=0, res_count=200.
- Overflow/carry: 0xFFFFFFFF + 0xFFFFFFFF, c_in=1 -> sum=0xFFFFFFFF, c_out=1, ovf=0, neg=1. 0x7FFFFFFF + 1 -> sum=0x80000000, ovf=1, c_out=0 (0x7FFFFFFF with ADDER_SAT_EN), ovf_count=1.
- Signed: -10 (0xFFFFFFF6) + 5 -> 0xFFFFFFFB, neg=1. -10 + -5 -> 0xFFFFFFF1, c_out=1, ovf=0. -1 + 1 -> sum=0, zero=1, c_out=1.
- Backpressure: hold out_ready=0 and present 4 triples -> exactly 2 accepted, then in_ready=0. sum holds stable. Release out_ready -> results emerge in order, none lost.
- Reset mid-flight: rst_n=0 for 1 clk with 2 results buffered -> out_valid=0, counters=0 next cycle, no stale result afterwards.
- Streaming with random out_ready toggling over 1000 random triples -> scoreboard matches in order, and res_count equals the number of output handshakes modulo 2^16.
